// File: rtl/spin_seq_pkg.sv
// Shared types and constants for the spin run sequencer: FSM state encoding
// and the default spin-word width and RF depth.
package spin_seq_pkg;

  localparam int N_SPIN   = 50;
  localparam int RF_DEPTH = 200;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ANNEAL,
    S_SETTLE,
    S_SAMPLE,
    S_GAP,
    S_DONE
  } state_e;

  // Run + rerun total, clamped to the number of RF entries available.
  function automatic logic [8:0] sat_total(input logic [7:0] runs,
                                           input logic [7:0] reruns,
                                           input logic [8:0] depth);
    logic [8:0] sum;
    sum = {1'b0, runs} + {1'b0, reruns};
    return (sum > depth) ? depth : sum;
  endfunction

endpackage

// File: rtl/spin_seq_edge_det.sv
// Registered rising-edge detector: pulses for the cycle in which the input is
// high and its registered copy is still low.
module spin_seq_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_rise
);

  logic r_sig_q;

  // NOTE: sequential state is written with <= only, so every flop samples the
  // pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_sig_q <= 1'b0;
    else       r_sig_q <= i_sig;
  end

  assign o_rise = i_sig & ~r_sig_q;

endmodule

// File: rtl/spin_run_sequencer.sv
// Anneal run sequencer: drives CCII, waits settle, samples the spin array and
// strobes each captured word out; holds final_run once all runs are done.
module spin_run_sequencer #(
  parameter int N_SPIN   = spin_seq_pkg::N_SPIN,
  parameter int RF_DEPTH = spin_seq_pkg::RF_DEPTH,
  parameter int ANNEAL_W = 16,
  parameter int SETTLE_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                conf_sys_ctrl_reg_RESET,
  input  logic                conf_sys_ctrl_reg_START,
  input  logic [7:0]          conf_reg_total_run_count,
  input  logic [7:0]          conf_reg_total_rerun_count,
  input  logic [ANNEAL_W-1:0] conf_reg_anneal_cycles,
  input  logic [SETTLE_W-1:0] conf_reg_settle_cycles,
  input  logic [N_SPIN-1:0]   spin_raw,
  output logic                config_dig_spin_CCII_ena,
  output logic                config_dig_spin_read_out_ena,
  output logic                config_dig_spin_read_out_ena_q,
  output logic [N_SPIN-1:0]   spin_read_out,
  output logic                final_run,
  output logic [7:0]          run_index,
  output logic                busy
);

  import spin_seq_pkg::*;

  state_e              r_state, w_state_nxt;
  logic [ANNEAL_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]          r_run_index;
  logic [8:0]          r_total;
  logic [N_SPIN-1:0]   r_spin;
  logic                r_ro_q;

  logic                w_reset_edge, w_start_edge;
  logic [8:0]          w_total_sat;
  logic                w_last_run, w_run_inc, w_load_total;
  logic [ANNEAL_W-1:0] w_anneal_load, w_settle_load;

  spin_seq_edge_det u_reset_edge (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_sig (conf_sys_ctrl_reg_RESET),
    .o_rise(w_reset_edge)
  );

  spin_seq_edge_det u_start_edge (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_sig (conf_sys_ctrl_reg_START),
    .o_rise(w_start_edge)
  );

  assign w_total_sat   = sat_total(conf_reg_total_run_count, conf_reg_total_rerun_count,
                                   9'(RF_DEPTH));
  assign w_last_run    = (({1'b0, r_run_index} + 9'd1) == r_total);
  // Counter holds "cycles remaining minus one", so an anneal of 0 behaves as 1.
  assign w_anneal_load = (conf_reg_anneal_cycles == '0) ? '0 : conf_reg_anneal_cycles - 1'b1;
  assign w_settle_load = ANNEAL_W'(conf_reg_settle_cycles) - 1'b1;

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_run_inc    = 1'b0;
    w_load_total = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_load_total = 1'b1;
          if (w_total_sat == 9'd0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ANNEAL;
            w_cnt_nxt   = w_anneal_load;
          end
        end
      end
      S_ANNEAL: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (conf_reg_settle_cycles == '0) begin
          w_state_nxt = S_SAMPLE;
        end else begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = w_settle_load;
        end
      end
      S_SETTLE: begin
        if (r_cnt != '0) w_cnt_nxt   = r_cnt - 1'b1;
        else             w_state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        w_state_nxt = S_GAP;
        w_cnt_nxt   = ANNEAL_W'(1);
      end
      S_GAP: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (w_last_run) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_ANNEAL;
          w_cnt_nxt   = w_anneal_load;
          w_run_inc   = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the captured spin word is a plain register, not a memory, so it is
  // reset along with the rest of the state and reads 0 until the first sample.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_reset_edge) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_run_index <= '0;
      r_total     <= '0;
      r_spin      <= '0;
      r_ro_q      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ro_q  <= (r_state == S_SAMPLE);
      if (w_load_total)          r_total     <= w_total_sat;
      if (w_run_inc)             r_run_index <= r_run_index + 8'd1;
      if (r_state == S_SAMPLE)   r_spin      <= spin_raw;
    end
  end

  assign config_dig_spin_CCII_ena       = (r_state == S_ANNEAL);
  assign config_dig_spin_read_out_ena   = (r_state == S_SAMPLE);
  assign config_dig_spin_read_out_ena_q = r_ro_q;
  assign spin_read_out                  = r_spin;
  assign final_run                      = (r_state == S_DONE);
  assign run_index                      = r_run_index;
  assign busy                           = (r_state != S_IDLE) && (r_state != S_DONE);

endmodule

// File: tb/tb_spin_run_sequencer.sv
// Self-checking bench for spin_run_sequencer: table-driven sessions plus
// hand-written corner sequences, with a scoreboard on captured spin words.
module tb_spin_run_sequencer;

  localparam logic [49:0] FIXED_WORD = 50'h2_AAAA_5555_1234;

  logic        clk = 1'b0;
  logic        rst;
  logic        reset_in, start_in;
  logic [7:0]  run_cnt, rerun_cnt;
  logic [15:0] anneal_cnt;
  logic [7:0]  settle_cnt;
  logic [49:0] spin_raw;
  logic        ccii, ro, roq, final_run, busy;
  logic [49:0] spin_read_out;
  logic [7:0]  run_index;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0]  run;
    logic [7:0]  rerun;
    logic [15:0] anneal;
    logic [7:0]  settle;
    int          exp_strobes;
    int          exp_cycles;
    int          exp_ccii_len;
    int          exp_last;
  } vec_t;

  vec_t vecs [6];

  // Monitor state
  bit          rand_en = 1'b1;
  int          mon_cyc = 0;
  int          mon_strobes, mon_ccii_cycles, mon_ccii_len, mon_viol, mon_last_q;
  int          mon_exp_ccii_len;
  bit          mon_prev_ro;
  logic [49:0] sb_q [$];

  spin_run_sequencer dut (
    .i_clk                         (clk),
    .i_rst                         (rst),
    .conf_sys_ctrl_reg_RESET       (reset_in),
    .conf_sys_ctrl_reg_START       (start_in),
    .conf_reg_total_run_count      (run_cnt),
    .conf_reg_total_rerun_count    (rerun_cnt),
    .conf_reg_anneal_cycles        (anneal_cnt),
    .conf_reg_settle_cycles        (settle_cnt),
    .spin_raw                      (spin_raw),
    .config_dig_spin_CCII_ena      (ccii),
    .config_dig_spin_read_out_ena  (ro),
    .config_dig_spin_read_out_ena_q(roq),
    .spin_read_out                 (spin_read_out),
    .final_run                     (final_run),
    .run_index                     (run_index),
    .busy                          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon_clear();
    mon_strobes     = 0;
    mon_ccii_cycles = 0;
    mon_ccii_len    = 0;
    mon_viol        = 0;
    mon_last_q      = -100;
    sb_q.delete();
  endtask

  // Random spin word each cycle, changed just after the active edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_en) spin_raw = 50'({$urandom(), $urandom()});
  end

  // Protocol monitor and scoreboard: words are queued at the sample strobe and
  // compared when the delayed strobe says spin_read_out is valid.
  always @(negedge clk) begin
    if (ccii && ro)  mon_viol++;
    if (ccii && roq) mon_viol++;
    if (ro && mon_prev_ro) mon_viol++;
    if (ccii) begin
      mon_ccii_cycles++;
      mon_ccii_len++;
    end else if (mon_ccii_len != 0) begin
      if (mon_exp_ccii_len != 0 && mon_ccii_len != mon_exp_ccii_len) mon_viol++;
      mon_ccii_len = 0;
    end
    if (ro) begin
      mon_strobes++;
      sb_q.push_back(spin_raw);
    end
    if (roq) begin
      if (mon_cyc - mon_last_q < 3) mon_viol++;
      mon_last_q = mon_cyc;
      if (sb_q.size() == 0) mon_viol++;
      else check("spin_read_out vs scoreboard", spin_read_out, sb_q.pop_front());
    end
    mon_prev_ro = ro;
    mon_cyc++;
  end

  task automatic pulse_start();
    @(posedge clk); #1 start_in = 1'b1;
    @(posedge clk); #1 start_in = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset_in = 1'b1;
    @(posedge clk); #1 reset_in = 1'b0;
  endtask

  task automatic wait_final(output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (final_run) begin
        ok = 1'b1;
        break;
      end
      cycles++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    bit ok;
    int strobes_at_done;
    run_cnt    = v.run;
    rerun_cnt  = v.rerun;
    anneal_cnt = v.anneal;
    settle_cnt = v.settle;
    mon_clear();
    mon_exp_ccii_len = v.exp_ccii_len;
    pulse_start();
    wait_final(cyc, ok);
    check($sformatf("v%0d final_run reached", idx), 64'(ok), 1);
    check($sformatf("v%0d session cycles", idx), cyc, v.exp_cycles);
    check($sformatf("v%0d strobe count", idx), mon_strobes, v.exp_strobes);
    check($sformatf("v%0d CCII cycles", idx), mon_ccii_cycles, v.exp_strobes * v.exp_ccii_len);
    check($sformatf("v%0d last run_index", idx), run_index, v.exp_last);
    check($sformatf("v%0d busy in DONE", idx), busy, 0);
    check($sformatf("v%0d protocol violations", idx), mon_viol, 0);
    check($sformatf("v%0d scoreboard drained", idx), sb_q.size(), 0);
    strobes_at_done = mon_strobes;
    pulse_start();
    repeat (3) @(negedge clk);
    check($sformatf("v%0d DONE ignores START", idx), final_run, 1);
    check($sformatf("v%0d no strobe after DONE", idx), mon_strobes, strobes_at_done);
    pulse_reset();
    @(negedge clk);
    check($sformatf("v%0d final_run after RESET", idx), final_run, 0);
    check($sformatf("v%0d run_index after RESET", idx), run_index, 0);
    check($sformatf("v%0d spin_read_out after RESET", idx), spin_read_out, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  ok;
    int  cnt;

    //          run    rerun  anneal  settle strobes cycles ccii last
    vecs[0] = '{8'd2,   8'd1,   16'd4, 8'd2,   3,     27,   4,   2};
    vecs[1] = '{8'd0,   8'd0,   16'd4, 8'd2,   0,      0,   4,   0};
    vecs[2] = '{8'd150, 8'd100, 16'd1, 8'd0, 200,    800,   1, 199};
    vecs[3] = '{8'd1,   8'd0,   16'd0, 8'd0,   1,      4,   1,   0};
    vecs[4] = '{8'd0,   8'd5,   16'd3, 8'd1,   5,     35,   3,   4};
    vecs[5] = '{8'd255, 8'd255, 16'd0, 8'd3, 200,   1400,   1, 199};

    rst        = 1'b1;
    reset_in   = 1'b0;
    start_in   = 1'b0;
    run_cnt    = 8'd0;
    rerun_cnt  = 8'd0;
    anneal_cnt = 16'd0;
    settle_cnt = 8'd0;
    spin_raw   = '0;
    mon_exp_ccii_len = 0;
    mon_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset CCII_ena", ccii, 0);
    check("reset read_out_ena", ro, 0);
    check("reset read_out_ena_q", roq, 0);
    check("reset spin_read_out", spin_read_out, 0);
    check("reset final_run", final_run, 0);
    check("reset run_index", run_index, 0);
    check("reset busy", busy, 0);
    #1 rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // RESET edge in the middle of run 3's anneal, then a clean restart.
    run_cnt = 8'd5; rerun_cnt = 8'd0; anneal_cnt = 16'd6; settle_cnt = 8'd1;
    mon_clear();
    mon_exp_ccii_len = 6;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (ccii && run_index == 8'd3) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach ANNEAL of run 3", 64'(ok), 1);
    mon_exp_ccii_len = 0;
    pulse_reset();
    @(negedge clk);
    check("mid-run RESET CCII_ena", ccii, 0);
    check("mid-run RESET run_index", run_index, 0);
    check("mid-run RESET busy", busy, 0);
    mon_clear();
    mon_exp_ccii_len = 6;
    pulse_start();
    @(negedge clk);
    check("restart CCII_ena", ccii, 1);
    check("restart run_index", run_index, 0);
    wait_final(cyc, ok);
    check("restart final_run reached", 64'(ok), 1);
    check("restart strobe count", mon_strobes, 5);
    check("restart protocol violations", mon_viol, 0);
    pulse_reset();

    // RESET and START edges in the same cycle: RESET wins, stays idle.
    run_cnt = 8'd2;
    @(posedge clk); #1 reset_in = 1'b1; start_in = 1'b1;
    @(posedge clk); #1 reset_in = 1'b0; start_in = 1'b0;
    @(negedge clk);
    check("RESET beats START busy", busy, 0);
    check("RESET beats START CCII_ena", ccii, 0);
    check("RESET beats START final_run", final_run, 0);

    // Fixed word captured at SAMPLE, input changed afterwards; START while busy.
    rand_en = 1'b0;
    @(posedge clk); #1 spin_raw = FIXED_WORD;
    run_cnt = 8'd1; rerun_cnt = 8'd0; anneal_cnt = 16'd8; settle_cnt = 8'd1;
    mon_clear();
    mon_exp_ccii_len = 8;
    pulse_start();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ro) begin
        ok = 1'b1;
        break;
      end
    end
    check("sample strobe seen", 64'(ok), 1);
    @(posedge clk); #1 spin_raw = ~FIXED_WORD;
    @(negedge clk);
    check("read_out_ena_q after sample", roq, 1);
    check("captured word valid with _q", spin_read_out, 64'(FIXED_WORD));
    repeat (3) @(negedge clk);
    check("captured word held", spin_read_out, 64'(FIXED_WORD));
    wait_final(cyc, ok);
    check("busy START ignored strobes", mon_strobes, 1);
    check("busy START ignored run_index", run_index, 0);
    check("fixed word protocol violations", mon_viol, 0);
    cnt = sb_q.size();
    check("fixed word scoreboard drained", cnt, 0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
